keycode_event_decoder: RTL
==========================

// Module: keycode_event_decoder
// PURPOSE
//  Parametrised USB-keyboard action decoder that sits between the NIOS keycode register and game logic.
//  - Matches NUM_SLOTS report bytes against a run-time programmable key map of NUM_ACTIONS entries.
//  - Debounces each action on a frame tick.
//  - Emits per-action level (held), one-cycle press/release pulses, and auto-repeat pulses.
//  - Replaces fixed per-key compare logic, so player bindings (e.g. 1P/2P) change without resynthesis.
// PARAMETERS
//  NUM_SLOTS      4   number of 8-bit key slots in keycode (keycode width = 8*NUM_SLOTS)
//  NUM_ACTIONS    12  number of decoded actions
//  STABLE_TICKS   2   consecutive ticks a changed raw value must persist before held changes (>=1)
//  REPEAT_DELAY   15  ticks from press to first repeat pulse; 0 disables auto-repeat
//  REPEAT_PERIOD  4   ticks between subsequent repeat pulses (>=1)
// PORTS
//  Clk       in   1                 system clock
//  Reset     in   1                 synchronous, active-high reset
//  tick      in   1                 one-Clk-wide frame tick (e.g. per vsync); all timing counts ticks
//  keycode   in   8*NUM_SLOTS       raw keyboard report, slot k = keycode[8k+7:8k]
//  keymap    in   8*NUM_ACTIONS     USB usage code for action i = keymap[8i+7:8i]; 8'h00 = unbound
//  held      out  NUM_ACTIONS       debounced action level
//  pressed   out  NUM_ACTIONS       one-Clk pulse when held rises
//  released  out  NUM_ACTIONS       one-Clk pulse when held falls
//  repeat    out  NUM_ACTIONS       one-Clk auto-repeat pulse while held
//  rollover  out  1                 registered: current report is ErrorRollOver (all slots 8'h01)
// BEHAVIOUR
//  - Reset: raw_q, held, pressed, released, repeat, rollover, all counters and repeat phase = 0.
//  - Match: match[i] = (keymap[i] != 0) && any slot == keymap[i].
//  - Raw stage:
//    - raw_q <= match every Clk, except when all slots == 8'h01; then raw_q holds its value
//      (rollover report ignored).
//    - rollover <= (all slots == 8'h01).
//  - Debounce, per action, evaluated only on tick cycles:
//    - raw_q[i]==held[i] -> cnt[i]<=0.
//    - else if cnt[i]==STABLE_TICKS-1 -> held[i]<=raw_q[i], cnt[i]<=0.
//    - else cnt[i]++.
//    - A glitch shorter than STABLE_TICKS ticks never reaches held.
//    - STABLE_TICKS=1: held follows raw_q on the first tick after the change.
//  - Latency (STABLE_TICKS=N): keycode change at edge t; raw_q valid after t+1.
//    held changes at the Nth tick edge after raw_q changed.
//  - Pulses:
//    - pressed[i] / released[i] assert in the same cycle held[i] first shows the new value.
//    - Pulses are registered and last exactly one Clk; they deassert the following cycle, tick or not.
//  - Auto-repeat, per action (rcnt[i], phase[i]; phase 0 = initial delay, 1 = periodic):
//    - held[i]==0 or held rising this tick -> rcnt<=0, phase<=0.
//    - tick && held[i] && limit reached (phase0: rcnt==REPEAT_DELAY-1; phase1: rcnt==REPEAT_PERIOD-1)
//      -> repeat[i] pulses, rcnt<=0, phase<=1.
//    - otherwise on tick while held, rcnt++.
//    - REPEAT_DELAY=0: repeat constantly 0.
//    - Release while repeating clears state with no further repeat pulse.
//  - Counter widths: $clog2 of max(limit,2); counters never wrap (reset at limit).
//  - keymap may change at any time: the new match feeds raw_q the next Clk and is debounced normally.
//    No spurious pulse unless held actually changes.
//  - Duplicate map entries are legal; both actions assert identically.
//  - Reset mid-press: all outputs 0 the cycle after reset. A key still down re-debounces and
//    re-issues pressed.
// TESTING
//  - Defaults, tick every 4 Clk, keymap[0]=8'h52.
//    Drive keycode=32'h0000_5200 -> held[0]=1 with pressed[0] 1-cycle pulse at 2nd tick after raw_q;
//    no other bit set.
//  - Same setup, 8'h52 present for 1 tick only -> held/pressed/released never assert.
//  - Hold 8'h52 for 30 ticks -> repeat[0] pulses at ticks 15, 19, 23, 27 after held rise;
//    release -> released[0] pulse, no further repeat.
//  - Action 5 mapped to 8'h04, held.
//    keycode=32'h0101_0101 for 10 ticks -> rollover=1, held[5] stays 1, no released pulse.
//  - keymap[3]=8'h00, keycode with a 8'h00 slot -> held[3] stays 0.
//    Remap action 3 to 8'h1A while 1A is down -> pressed[3] after 2 ticks.
//  - Reset asserted while held[0]=1 and repeating -> all outputs 0 next cycle.
//    Key still down after reset -> pressed[0] reissued after 2 ticks.

Source files
------------

// File: rtl/keycode_event_if.sv
// Bus bundle between the keyboard-report source and the action decoder.
// The source drives the tick, report and key map; the decoder drives the per-action outputs.
interface keycode_event_if #(
  parameter int NUM_SLOTS   = 4,
  parameter int NUM_ACTIONS = 12
);
  logic                     tick;
  logic [8*NUM_SLOTS-1:0]   keycode;
  logic [8*NUM_ACTIONS-1:0] keymap;
  logic [NUM_ACTIONS-1:0]   held;
  logic [NUM_ACTIONS-1:0]   pressed;
  logic [NUM_ACTIONS-1:0]   released;
  logic [NUM_ACTIONS-1:0]   repeat_pulse;
  logic                     rollover;

  modport master (
    output tick, keycode, keymap,
    input  held, pressed, released, repeat_pulse, rollover
  );

  modport slave (
    input  tick, keycode, keymap,
    output held, pressed, released, repeat_pulse, rollover
  );
endinterface

// File: rtl/keycode_event_decoder.sv
// Maps keyboard report slots onto programmable actions, debounces them on the frame tick
// and produces held level, press/release pulses and auto-repeat pulses per action.
//
// Auto-repeat phase, per action:
//   state       | meaning
//   PH_DELAY    | held, waiting REPEAT_DELAY ticks for the first repeat
//   PH_PERIODIC | held, repeating every REPEAT_PERIOD ticks
module keycode_event_decoder #(
  parameter int NUM_SLOTS     = 4,
  parameter int NUM_ACTIONS   = 12,
  parameter int STABLE_TICKS  = 2,
  parameter int REPEAT_DELAY  = 15,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic           clk,
  input  logic           reset,
  keycode_event_if.slave bus
);

  localparam int CW   = $clog2(STABLE_TICKS > 2 ? STABLE_TICKS : 2);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX > 2 ? RMAX : 2);

  localparam logic [CW-1:0] STABLE_LIM = CW'(STABLE_TICKS - 1);
  localparam logic [RW-1:0] DELAY_LIM  = RW'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
  localparam logic [RW-1:0] PERIOD_LIM = RW'(REPEAT_PERIOD - 1);
  localparam logic [8*NUM_SLOTS-1:0] ROLLOVER_RPT = {NUM_SLOTS{8'h01}};

  typedef enum logic {
    PH_DELAY    = 1'b0,
    PH_PERIODIC = 1'b1
  } phase_t;

  logic [NUM_ACTIONS-1:0] match;
  logic                   rollover_rpt;
  logic [NUM_ACTIONS-1:0] raw_q;
  logic [NUM_ACTIONS-1:0] held_q, held_nxt;
  logic [NUM_ACTIONS-1:0] pressed_q, released_q, rpt_q, rpt_nxt;
  logic                   rollover_q;
  logic [CW-1:0]          cnt_q     [NUM_ACTIONS];
  logic [CW-1:0]          cnt_nxt   [NUM_ACTIONS];
  logic [RW-1:0]          rcnt_q    [NUM_ACTIONS];
  logic [RW-1:0]          rcnt_nxt  [NUM_ACTIONS];
  phase_t                 phase_q   [NUM_ACTIONS];
  phase_t                 phase_nxt [NUM_ACTIONS];

  // Unbound actions (code 8'h00) never match, even against empty slots.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ACTIONS; i++) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (bus.keymap[8*i +: 8] != 8'h00 &&
            bus.keycode[8*k +: 8] == bus.keymap[8*i +: 8]) begin
          match[i] = 1'b1;
        end
      end
    end
  end

  assign rollover_rpt = (bus.keycode == ROLLOVER_RPT);

  always_comb begin
    held_nxt = held_q;
    rpt_nxt  = '0;
    for (int i = 0; i < NUM_ACTIONS; i++) begin
      cnt_nxt[i]   = cnt_q[i];
      rcnt_nxt[i]  = rcnt_q[i];
      phase_nxt[i] = phase_q[i];

      if (bus.tick) begin
        if (raw_q[i] == held_q[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt_q[i] == STABLE_LIM) begin
          held_nxt[i] = raw_q[i];
          cnt_nxt[i]  = '0;
        end else begin
          cnt_nxt[i] = cnt_q[i] + 1'b1;
        end
      end

      // Rising or falling this tick restarts the delay and suppresses any pulse.
      if (REPEAT_DELAY == 0 || !held_q[i] || !held_nxt[i]) begin
        rcnt_nxt[i]  = '0;
        phase_nxt[i] = PH_DELAY;
      end else if (bus.tick) begin
        if (rcnt_q[i] == ((phase_q[i] == PH_PERIODIC) ? PERIOD_LIM : DELAY_LIM)) begin
          rpt_nxt[i]   = 1'b1;
          rcnt_nxt[i]  = '0;
          phase_nxt[i] = PH_PERIODIC;
        end else begin
          rcnt_nxt[i] = rcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q      <= '0;
      held_q     <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      rpt_q      <= '0;
      rollover_q <= 1'b0;
      for (int i = 0; i < NUM_ACTIONS; i++) begin
        cnt_q[i]   <= '0;
        rcnt_q[i]  <= '0;
        phase_q[i] <= PH_DELAY;
      end
    end else begin
      // An ErrorRollOver report carries no key information, so keep the last real one.
      if (!rollover_rpt) begin
        raw_q <= match;
      end
      rollover_q <= rollover_rpt;
      held_q     <= held_nxt;
      pressed_q  <= held_nxt & ~held_q;
      released_q <= ~held_nxt & held_q;
      rpt_q      <= rpt_nxt;
      for (int i = 0; i < NUM_ACTIONS; i++) begin
        cnt_q[i]   <= cnt_nxt[i];
        rcnt_q[i]  <= rcnt_nxt[i];
        phase_q[i] <= phase_nxt[i];
      end
    end
  end

  assign bus.held         = held_q;
  assign bus.pressed      = pressed_q;
  assign bus.released     = released_q;
  assign bus.repeat_pulse = rpt_q;
  assign bus.rollover     = rollover_q;

endmodule
